// File: rtl/mod_mul_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_mul_if
// Description : Operand/result bundle for the secp256k1 modular multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_mul_if;
    logic [255:0] a_in;
    logic [255:0] b_in;
    logic         start;
    logic         busy;
    logic         done;
    logic [255:0] product;

    modport master (
        output a_in,
        output b_in,
        output start,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  a_in,
        input  b_in,
        input  start,
        output busy,
        output done,
        output product
    );
endinterface
`default_nettype wire

// File: rtl/mod_mul.sv
`default_nettype none
// ============================================================================
// Module      : mod_mul
// Description : Bit-serial (MSB-first) double-and-add modular multiplier mod P.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_mul #(
    parameter logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    mod_mul_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [256:0] c_p_ext = {1'b0, P};

    state_t       r_state, w_state_next;
    logic [255:0] r_ra, w_ra_next;
    logic [255:0] r_rb, w_rb_next;
    logic [255:0] r_acc, w_acc_next;
    logic [255:0] r_product, w_product_next;
    logic [7:0]   r_cnt, w_cnt_next;
    logic         r_busy, w_busy_next;
    logic         r_done, w_done_next;

    logic [256:0] w_dbl;
    logic [255:0] w_dbl_red;
    logic [256:0] w_sum;
    logic [255:0] w_sum_red;
    logic [255:0] w_step;
    logic [255:0] w_ra_red;
    logic [255:0] w_rb_red;

    // Both reduced terms are < P, so every 257-bit intermediate stays < 2P.
    assign w_dbl     = {r_acc, 1'b0};
    assign w_dbl_red = 256'((w_dbl >= c_p_ext) ? (w_dbl - c_p_ext) : w_dbl);
    assign w_sum     = {1'b0, w_dbl_red} + {1'b0, r_ra};
    assign w_sum_red = 256'((w_sum >= c_p_ext) ? (w_sum - c_p_ext) : w_sum);
    assign w_step    = r_rb[r_cnt] ? w_sum_red : w_dbl_red;

    // One subtraction suffices for raw operands since 2^256 < 2P.
    assign w_ra_red  = (r_ra >= P) ? (r_ra - P) : r_ra;
    assign w_rb_red  = (r_rb >= P) ? (r_rb - P) : r_rb;

    always_comb begin
        w_state_next   = r_state;
        w_ra_next      = r_ra;
        w_rb_next      = r_rb;
        w_acc_next     = r_acc;
        w_product_next = r_product;
        w_cnt_next     = r_cnt;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_ra_next    = bus.a_in;
                    w_rb_next    = bus.b_in;
                    w_busy_next  = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ra_next    = w_ra_red;
                w_rb_next    = w_rb_red;
                w_acc_next   = '0;
                w_cnt_next   = 8'd255;
                w_state_next = S_MUL;
            end
            S_MUL: begin
                w_acc_next = w_step;
                if (r_cnt == 8'd0) begin
                    w_product_next = w_step;
                    w_done_next    = 1'b1;
                    w_busy_next    = 1'b0;
                    w_state_next   = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ra      <= '0;
            r_rb      <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ra      <= w_ra_next;
            r_rb      <= w_rb_next;
            r_acc     <= w_acc_next;
            r_product <= w_product_next;
            r_cnt     <= w_cnt_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mod_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_mul
// Description : Directed self-checking bench for mod_mul over secp256k1 p.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_mul;

    localparam logic [255:0] c_p =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] c_half =
        256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18;
    localparam logic [255:0] c_two256 = 256'h1000003D1;   // 2^256 mod p

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    mod_mul_if bus ();

    mod_mul #(.P(c_p)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation and follow it to completion; optionally disturb inputs mid-run.
    task automatic run_op(input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] exp, input string tag, input bit disturb);
        int  lat;
        bit  seen;
        bit  busy_ok;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, " busy@E0"}, 256'(bus.busy), 256'd1);
        lat = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 300 && !seen; k++) begin
            if (disturb && k >= 10 && k < 30) begin
                bus.a_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                bus.b_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                bus.start = k[0];
            end else begin
                bus.start = 1'b0;
            end
            tick();
            if (bus.done) begin
                seen = 1'b1;
                lat  = k;
            end else if (!bus.busy) begin
                busy_ok = 1'b0;
            end
        end
        check({tag, " latency"}, 256'(lat), 256'd257);
        check({tag, " busy_high"}, 256'(busy_ok), 256'd1);
        check({tag, " busy@done"}, 256'(bus.busy), 256'd0);
        check({tag, " product"}, bus.product, exp);
        tick();
        check({tag, " done_pulse"}, 256'(bus.done), 256'd0);
    endtask

    initial begin
        logic [63:0]  ra;
        logic [63:0]  rb;
        logic [255:0] all1;
        bit           spurious;

        n_vec = 0;
        n_err = 0;
        all1  = '1;
        reset_n   = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.start = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        check("reset busy", 256'(bus.busy), 256'd0);
        check("reset done", 256'(bus.done), 256'd0);
        check("reset product", bus.product, 256'd0);
        tick();

        run_op(256'd3, 256'd5, 256'd15, "3x5", 1'b0);
        run_op(c_p - 1, c_p - 1, 256'd1, "(p-1)^2", 1'b0);
        run_op(c_p + 2, 256'd3, 256'd6, "(p+2)x3", 1'b0);
        run_op(256'd2, c_half, 256'd1, "2x(p+1)/2", 1'b0);
        run_op(256'd0, c_p - 5, 256'd0, "0xb", 1'b0);
        run_op(c_p - 7, c_p, 256'd0, "axp", 1'b0);
        run_op(c_p - 1, 256'd2, c_p - 2, "(p-1)x2", 1'b0);
        run_op(256'd1 << 255, 256'd2, c_two256, "2^255x2", 1'b0);
        run_op(256'd1 << 128, 256'd1 << 128, c_two256, "2^128sq", 1'b0);
        run_op(all1, all1, 256'h1000007A0000E8900, "ones_sq", 1'b0);

        // Inputs and start wiggle during MUL; result must reflect captured operands.
        run_op(256'd3, 256'd5, 256'd15, "disturb", 1'b1);

        // Reset mid-MUL discards the operation.
        bus.a_in  = 256'd7;
        bus.b_in  = 256'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst busy", 256'(bus.busy), 256'd0);
        check("midrst done", 256'(bus.done), 256'd0);
        check("midrst product", bus.product, 256'd0);
        spurious = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (bus.done || bus.busy) spurious = 1'b1;
        end
        check("midrst no_done", 256'(spurious), 256'd0);
        run_op(256'd7, 256'd9, 256'd63, "post_rst", 1'b0);

        // Small operands: the exact product is below p, so no reduction applies.
        for (int i = 0; i < 12; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_op(256'(ra), 256'(rb), 256'(ra) * 256'(rb), "rand64", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_mul.md
# mod_mul

Sequential modular multiplier over the secp256k1 field prime p. It computes `product = (a_in * b_in) mod p` with an MSB-first interleaved double-and-add loop that processes one multiplier bit per cycle. It sits beside `mod_inv` in the field-arithmetic layer and serves two roles:
- it does the forward multiplications for point arithmetic;
- it checks inversion results, since `x * x^-1 mod p` must equal 1.

## Interface
Parameters:
- `P`, default `256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F`, the field modulus.

Ports:
- `clk`, input, 1 bit: the single clock. All state changes on its rising edge.
- `reset_n`, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `a_in`, input, 256 bits: multiplicand. Any value is accepted; values ≥ P are reduced internally.
- `b_in`, input, 256 bits: multiplier. Any value is accepted; values ≥ P are reduced internally.
- `start`, input, 1 bit: request. Sampled only in IDLE.
- `busy`, output, 1 bit: high in LOAD and MUL.
- `done`, output, 1 bit: one-cycle pulse when `product` becomes valid.
- `product`, output, 256 bits: result. Always < P. Held until the next completion.

## Operation
- **Reset** (`reset_n`=0 at an edge):
  - state goes to IDLE;
  - `busy`=0, `done`=0, `product`=0;
  - internal operand, accumulator and counter registers are cleared.
  - Reset takes priority over everything, including mid-operation; the operation in flight is discarded with no `done`.
- **States:** IDLE, LOAD, MUL, DONE. All outputs are registered.
- **IDLE:**
  - If `start`=1, capture `a_in` and `b_in` into `ra` and `rb` and go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD:**
  - Reduce each operand with one conditional subtraction: `x ≥ P ? x − P : x`. A single subtraction is enough because 2^256 < 2P.
  - Clear `acc` to 0 and set `cnt`=255.
  - Go to MUL.
- **MUL** (one edge per bit, `cnt` from 255 down to 0):
  - `t = 2*acc` (257 bits), then `t = (t ≥ P) ? t − P : t`.
  - If `rb[cnt]`=1: `u = t + ra` (257 bits), then `u = (u ≥ P) ? u − P : u`.
  - Otherwise `u = t`.
  - Store `acc ← u[255:0]`.
  - When `cnt`=0, write the new `acc` to `product`, set `done`=1 and go to DONE.
  - Otherwise decrement `cnt`.
- **DONE:** clear `done` to 0 and return to IDLE.
- **Width rules:**
  - All intermediate sums and doublings are 257 bits wide.
  - After each conditional subtraction the value is < P, so it is truncated to 256 bits.
  - No path ever holds a value ≥ 2P.
- **`start` outside IDLE** (LOAD, MUL, DONE) is ignored. It is not queued.
- **Input stability:** `a_in` and `b_in` are sampled only on the start edge in IDLE. Changing them afterwards has no effect.

## Timing
- Let E0 be the edge at which `start`=1 is sampled in IDLE.
- LOAD completes at E1. MUL runs from E2 to E257, covering 256 edges for bits 255 down to 0.
- `product` is updated and `done` goes to 1 at E257. `done` returns to 0 at E258.
- Latency from the start edge to `done` high: 257 cycles. `done` is high for exactly one cycle.
- Earliest next accepted `start`: E259. A new `start` can be sampled at E258 only if the state is already IDLE, which it is not; the state reaches IDLE at E258, so the first sampling in IDLE is E259.
- `busy`:
  - goes to 1 at E0;
  - stays 1 through LOAD and MUL;
  - goes to 0 at E257, when `done` rises, so `busy` and `done` are never high together.
- `product` changes only at the `done` edge or on reset.

## Test plan
- Reset, then `a_in`=3, `b_in`=5 with a `start` pulse → after 257 cycles `done`=1 for exactly one cycle, `product`=15, `busy` waveform as specified.
- `a_in`=P−1, `b_in`=P−1 → `product`=1. Also `a_in`=P+2, `b_in`=3 → `product`=6, which checks the LOAD reduction.
- `a_in`=2, `b_in`=(P+1)/2=`7FFF…FFFF7FFFFE18` → `product`=1. This is the inverse check and must match the value `mod_inv` returns for input 2.
- `a_in`=0 with any `b_in`, and `b_in`=P with any `a_in` → `product`=0.
- Toggle `start` and change `a_in`/`b_in` during MUL → no restart, and the result equals the product of the originally captured operands.
- Drive `reset_n`=0 for one edge mid-MUL → `busy`=0, `done`=0, `product`=0 next cycle, no `done` pulse. A new `start` afterwards produces the correct result.
- Randomised regression: 1000 random operand pairs compared against a reference model.
